// File: rtl/vec_alu_seq.sv
// vec_alu_seq: issue-side sequencer for the vector ALU lanes.
// Fetches vs1/vs2, runs all lanes to completion, OR-merges results and writes vd back.
module vec_alu_seq #(
    parameter int         VLEN     = 128,
    parameter int         NB_LANES = 1,
    parameter logic [9:0] TIMEOUT  = 10'd1023
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [5:0]                        req_opcode,
    input  logic [2:0]                        req_vsew,
    input  logic [4:0]                        req_vs1,
    input  logic [4:0]                        req_vs2,
    input  logic [4:0]                        req_vd,
    output logic [4:0]                        rf_raddr,
    input  logic [VLEN-1:0]                   rf_rdata,
    output logic                              rf_we,
    output logic [4:0]                        rf_waddr,
    output logic [VLEN-1:0]                   rf_wdata,
    output logic                              lane_run,
    output logic [5:0]                        lane_opcode,
    output logic [2:0]                        lane_vsew,
    output logic [VLEN-1:0]                   lane_vs1,
    output logic [VLEN-1:0]                   lane_vs2,
    input  logic [(1<<NB_LANES)-1:0]          lane_done,
    input  logic [(1<<NB_LANES)*VLEN-1:0]     lane_vd,
    output logic                              resp_valid,
    output logic                              resp_err
);
    localparam int NL = 1 << NB_LANES;
    typedef enum logic [2:0] {IDLE, RD1, RD2, LOAD, RUN, WB, ERR} state_t;
    state_t          state;
    logic [4:0]      vs2_idx;
    logic [9:0]      cnt;
    logic [VLEN-1:0] merged;
    logic            legal;
    always_comb begin
        merged = '0;
        for (int i = 0; i < NL; i++) merged = merged | lane_vd[i*VLEN +: VLEN];
        legal = (req_opcode == 6'b001001) && (req_vsew <= 3'd3);
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            rf_we       <= 1'b0;
            lane_run    <= 1'b0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            rf_raddr    <= '0;
            rf_waddr    <= '0;
            lane_opcode <= '0;
            lane_vsew   <= '0;
            rf_wdata    <= '0;
            lane_vs1    <= '0;
            lane_vs2    <= '0;
            vs2_idx     <= '0;
            cnt         <= '0;
        end else begin
            rf_we      <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        // illegal requests leave the lanes and register file interface untouched
                        if (legal) begin
                            lane_opcode <= req_opcode;
                            lane_vsew   <= req_vsew;
                            rf_raddr    <= req_vs1;
                            vs2_idx     <= req_vs2;
                            rf_waddr    <= req_vd;
                            state       <= RD1;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= ERR;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                RD1: begin
                    rf_raddr <= vs2_idx;
                    state    <= RD2;
                end
                RD2: begin
                    lane_vs1 <= rf_rdata;
                    state    <= LOAD;
                end
                LOAD: begin
                    lane_vs2 <= rf_rdata;
                    cnt      <= '0;
                    lane_run <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    if (&lane_done) begin
                        rf_wdata   <= merged;
                        rf_we      <= 1'b1;
                        resp_valid <= 1'b1;
                        lane_run   <= 1'b0;
                        state      <= WB;
                    end else if (cnt == TIMEOUT) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        lane_run   <= 1'b0;
                        state      <= ERR;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 10'd1;
                    end
                end
                WB, ERR: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_alu_seq.sv
// tb_vec_alu_seq: randomized self-checking bench for vec_alu_seq with
// a register file model and behavioural lanes that own interleaved elements.
module tb_vec_alu_seq;
    localparam int VLEN = 128;
    localparam int NL   = 2;
    logic              clk, resetn, req_valid, req_ready;
    logic [5:0]        req_opcode;
    logic [2:0]        req_vsew;
    logic [4:0]        req_vs1, req_vs2, req_vd, rf_raddr, rf_waddr;
    logic [VLEN-1:0]   rf_rdata, rf_wdata, lane_vs1, lane_vs2;
    logic              rf_we, lane_run, resp_valid, resp_err;
    logic [5:0]        lane_opcode;
    logic [2:0]        lane_vsew;
    logic [NL-1:0]     lane_done;
    logic [NL*VLEN-1:0] lane_vd;
    logic [VLEN-1:0]   rf [32];
    int                errors = 0, checks = 0;
    int                dly [NL];
    logic              force_en;
    logic [NL-1:0]     force_val;
    int                run_cycles;

    vec_alu_seq #(.VLEN(VLEN), .NB_LANES(1), .TIMEOUT(10'd20)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_vsew(req_vsew), .req_vs1(req_vs1), .req_vs2(req_vs2),
        .req_vd(req_vd), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .lane_run(lane_run),
        .lane_opcode(lane_opcode), .lane_vsew(lane_vsew), .lane_vs1(lane_vs1),
        .lane_vs2(lane_vs2), .lane_done(lane_done), .lane_vd(lane_vd),
        .resp_valid(resp_valid), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rf_rdata   <= rf[rf_raddr];
        run_cycles <= lane_run ? run_cycles + 1 : 0;
    end

    // lane i finishes dly[i] cycles into RUN and owns elements e with e % NL == i
    always_comb begin
        lane_done = '0;
        lane_vd   = '0;
        for (int i = 0; i < NL; i++) begin
            lane_done[i] = force_en ? force_val[i] : (lane_run && run_cycles >= dly[i]);
            for (int p = 0; p < VLEN; p++)
                if (((p / (8 << lane_vsew)) % NL) == i)
                    lane_vd[i*VLEN + p] = lane_vs1[p] & lane_vs2[p];
        end
    end

    task automatic run_txn(input logic [5:0] op, input logic [2:0] sew,
                           input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                           output int t_run, output int n_run, output int n_we,
                           output logic [4:0] waddr, output logic [VLEN-1:0] wdata,
                           output int t_resp, output logic err, output logic ready_after,
                           output logic raddr_moved);
        logic [4:0] ra0;
        t_run = -1; n_run = 0; n_we = 0; waddr = '0; wdata = '0;
        t_resp = -1; err = 1'b0; ready_after = 1'b0; raddr_moved = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_opcode = op; req_vsew = sew;
        req_vs1 = a; req_vs2 = b; req_vd = d;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        ra0 = rf_raddr;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            if (lane_run) begin
                if (t_run < 0) t_run = c;
                n_run++;
            end
            if (rf_raddr !== ra0) raddr_moved = 1'b1;
            if (rf_we) begin
                n_we++; waddr = rf_waddr; wdata = rf_wdata; rf[rf_waddr] = rf_wdata;
            end
            if (resp_valid) begin
                t_resp = c; err = resp_err;
                @(negedge clk);
                ready_after = req_ready;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rf_we, lane_run, resp_valid, resp_err, rf_raddr, rf_waddr,
             lane_opcode, lane_vsew} !== '0 || {rf_wdata, lane_vs1, lane_vs2} !== '0) begin
            errors++;
            $display("FAIL reset_values: ready=%b we=%b run=%b rv=%b re=%b ra=%0d wa=%0d wd=%h want all zero",
                     req_ready, rf_we, lane_run, resp_valid, resp_err, rf_raddr, rf_waddr, rf_wdata);
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_rise: got %b want 1", req_ready);
        end
    endtask

    task automatic test_basic;
        int t_run, n_run, n_we, t_resp;
        logic [4:0] wa; logic [VLEN-1:0] wd, expv; logic err, rdy, mv;
        rf[1] = '1;
        rf[2] = 128'h0123456789ABCDEF_FEDCBA9876543210;
        expv = rf[1] & rf[2];
        dly[0] = 0; dly[1] = 0;
        run_txn(6'b001001, 3'd0, 5'd1, 5'd2, 5'd3, t_run, n_run, n_we, wa, wd, t_resp, err, rdy, mv);
        checks++;
        if (t_run !== 4) begin errors++; $display("FAIL basic_run_start: got %0d want 4", t_run); end
        checks++;
        if (n_we !== 1 || wa !== 5'd3 || wd !== expv) begin
            errors++; $display("FAIL basic_write: n=%0d wa=%0d wd=%h want n=1 wa=3 wd=%h", n_we, wa, wd, expv);
        end
        checks++;
        if (t_resp !== 5 || err !== 1'b0 || rdy !== 1'b1) begin
            errors++; $display("FAIL basic_resp: t=%0d err=%b rdy=%b want t=5 err=0 rdy=1", t_resp, err, rdy);
        end
    endtask

    task automatic test_alias;
        int t_run, n_run, n_we, t_resp;
        logic [4:0] wa; logic [VLEN-1:0] wd, r5; logic err, rdy, mv;
        r5 = {16{8'hA5}};
        rf[5] = r5;
        dly[0] = 2; dly[1] = 1;
        run_txn(6'b001001, 3'd2, 5'd5, 5'd5, 5'd5, t_run, n_run, n_we, wa, wd, t_resp, err, rdy, mv);
        checks++;
        if (n_we !== 1 || wa !== 5'd5 || wd !== r5 || rf[5] !== r5) begin
            errors++; $display("FAIL alias_write: n=%0d wa=%0d wd=%h want n=1 wa=5 wd=%h", n_we, wa, wd, r5);
        end
        checks++;
        if (t_resp !== 7 || err !== 1'b0) begin
            errors++; $display("FAIL alias_resp: t=%0d err=%b want t=7 err=0", t_resp, err);
        end
    endtask

    task automatic test_illegal;
        int t_run, n_run, n_we, t_resp;
        logic [4:0] wa; logic [VLEN-1:0] wd; logic err, rdy, mv;
        logic [5:0] ops [2] = '{6'b000000, 6'b001001};
        logic [2:0] sews [2] = '{3'd0, 3'b100};
        for (int k = 0; k < 2; k++) begin
            run_txn(ops[k], sews[k], 5'd7, 5'd8, 5'd9, t_run, n_run, n_we, wa, wd, t_resp, err, rdy, mv);
            checks++;
            if (t_resp !== 1 || err !== 1'b1 || rdy !== 1'b1) begin
                errors++; $display("FAIL illegal%0d_resp: t=%0d err=%b rdy=%b want t=1 err=1 rdy=1", k, t_resp, err, rdy);
            end
            checks++;
            if (n_run !== 0 || n_we !== 0 || mv !== 1'b0) begin
                errors++; $display("FAIL illegal%0d_side: run=%0d we=%0d raddr_moved=%b want 0 0 0", k, n_run, n_we, mv);
            end
        end
    endtask

    task automatic test_stagger;
        int t_run, n_run, n_we, t_resp;
        logic [4:0] wa; logic [VLEN-1:0] wd, expv; logic err, rdy, mv;
        rf[10] = {$urandom, $urandom, $urandom, $urandom};
        rf[11] = {$urandom, $urandom, $urandom, $urandom};
        expv = rf[10] & rf[11];
        dly[0] = 3; dly[1] = 10;
        run_txn(6'b001001, 3'd1, 5'd10, 5'd11, 5'd12, t_run, n_run, n_we, wa, wd, t_resp, err, rdy, mv);
        checks++;
        if (n_run !== 11 || t_resp !== 15) begin
            errors++; $display("FAIL stagger_timing: run=%0d t=%0d want run=11 t=15", n_run, t_resp);
        end
        checks++;
        if (wd !== expv || n_we !== 1 || err !== 1'b0) begin
            errors++; $display("FAIL stagger_data: wd=%h n=%0d err=%b want %h 1 0", wd, n_we, err, expv);
        end
    endtask

    task automatic test_timeout;
        int t_run, n_run, n_we, t_resp;
        logic [4:0] wa; logic [VLEN-1:0] wd; logic err, rdy, mv;
        force_en = 1'b1; force_val = 2'b01;
        run_txn(6'b001001, 3'd0, 5'd1, 5'd2, 5'd13, t_run, n_run, n_we, wa, wd, t_resp, err, rdy, mv);
        force_en = 1'b0;
        checks++;
        if (n_run !== 21 || t_resp !== 25 || err !== 1'b1) begin
            errors++; $display("FAIL timeout_resp: run=%0d t=%0d err=%b want run=21 t=25 err=1", n_run, t_resp, err);
        end
        checks++;
        if (n_we !== 0 || rdy !== 1'b1) begin
            errors++; $display("FAIL timeout_side: we=%0d rdy=%b want 0 1", n_we, rdy);
        end
    endtask

    task automatic test_reset_mid_run;
        int t_run, n_run, n_we, t_resp, bad;
        logic [4:0] wa; logic [VLEN-1:0] wd, expv; logic err, rdy, mv;
        dly[0] = 30; dly[1] = 30; bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_opcode = 6'b001001; req_vsew = 3'd0;
        req_vs1 = 5'd1; req_vs2 = 5'd2; req_vd = 5'd14;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !lane_run; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        checks++;
        if ({req_ready, rf_we, lane_run, resp_valid, resp_err, rf_raddr, rf_waddr,
             lane_opcode, lane_vsew} !== '0 || {rf_wdata, lane_vs1, lane_vs2} !== '0) begin
            errors++;
            $display("FAIL midrun_reset_values: ready=%b we=%b run=%b rv=%b ra=%0d wa=%0d vs1=%h want all zero",
                     req_ready, rf_we, lane_run, resp_valid, rf_raddr, rf_waddr, lane_vs1);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL midrun_ready: got %b want 1", req_ready); end
        for (int i = 0; i < 8; i++) begin
            if (rf_we || resp_valid || lane_run) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL midrun_quiet: got %0d active cycles want 0", bad); end
        dly[0] = 1; dly[1] = 2;
        expv = rf[1] & rf[2];
        run_txn(6'b001001, 3'd3, 5'd1, 5'd2, 5'd15, t_run, n_run, n_we, wa, wd, t_resp, err, rdy, mv);
        checks++;
        if (t_resp !== 7 || err !== 1'b0 || wa !== 5'd15 || wd !== expv) begin
            errors++; $display("FAIL midrun_fresh: t=%0d err=%b wa=%0d wd=%h want t=7 err=0 wa=15 wd=%h", t_resp, err, wa, wd, expv);
        end
    endtask

    task automatic test_back_to_back;
        int acc [$];
        int n_we, n_resp, bad;
        n_we = 0; n_resp = 0; bad = 0;
        dly[0] = 0; dly[1] = 0;
        @(negedge clk);
        req_valid = 1'b1; req_opcode = 6'b001001; req_vsew = 3'd0;
        req_vs1 = 5'd20; req_vs2 = 5'd21; req_vd = 5'd22;
        for (int c = 0; c < 40; c++) begin
            if (c == 30) req_valid = 1'b0;
            if (req_valid && req_ready) acc.push_back(c);
            if (req_ready && (lane_run || rf_we || resp_valid)) bad++;
            if (rf_we) begin n_we++; rf[rf_waddr] = rf_wdata; end
            if (resp_valid) n_resp++;
            @(negedge clk);
        end
        checks++;
        if (acc.size() < 2 || acc[1] - acc[0] !== 6) begin
            errors++; $display("FAIL b2b_interval: accepts=%0d gap=%0d want gap 6", acc.size(),
                               acc.size() >= 2 ? acc[1] - acc[0] : -1);
        end
        checks++;
        if (n_we !== acc.size() || n_resp !== acc.size() || bad !== 0) begin
            errors++; $display("FAIL b2b_count: we=%0d resp=%0d acc=%0d bad=%0d", n_we, n_resp, acc.size(), bad);
        end
    endtask

    task automatic test_random;
        int t_run, n_run, n_we, t_resp, mx;
        logic [4:0] wa, a, b, d; logic [VLEN-1:0] wd, expv; logic err, rdy, mv;
        logic [2:0] sew;
        for (int k = 0; k < 8; k++) begin
            a = 5'($urandom_range(0, 31)); b = 5'($urandom_range(0, 31)); d = 5'($urandom_range(0, 31));
            sew = 3'($urandom_range(0, 3));
            dly[0] = $urandom_range(0, 6); dly[1] = $urandom_range(0, 6);
            mx = dly[0] > dly[1] ? dly[0] : dly[1];
            expv = rf[a] & rf[b];
            run_txn(6'b001001, sew, a, b, d, t_run, n_run, n_we, wa, wd, t_resp, err, rdy, mv);
            checks++;
            if (wd !== expv || wa !== d || n_we !== 1 || err !== 1'b0 || t_resp !== 5 + mx) begin
                errors++;
                $display("FAIL random%0d: wd=%h wa=%0d n=%0d err=%b t=%0d want wd=%h wa=%0d n=1 err=0 t=%0d",
                         k, wd, wa, n_we, err, t_resp, expv, d, 5 + mx);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 1'b0; req_opcode = '0; req_vsew = '0;
        req_vs1 = '0; req_vs2 = '0; req_vd = '0;
        force_en = 1'b0; force_val = '0; dly[0] = 0; dly[1] = 0;
        test_reset;
        test_basic;
        test_alias;
        test_illegal;
        test_stagger;
        test_timeout;
        test_reset_mid_run;
        test_back_to_back;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vec_alu_seq.md
# vec_alu_seq

Issue-side sequencer for the vector ALU lanes. It accepts one vector arithmetic request from the core over a valid/ready handshake and fetches vs1/vs2 from the vector register file. It drives `run` to all lanes until every lane reports `done`, OR-merges the lane results, writes vd back to the register file and returns a one-cycle response to the core.

## Interface
- `VLEN`, 10'd128: vector register width in bits.
- `NB_LANES`, 2'b01: lane count is 2^NB_LANES (NL).
- `TIMEOUT`, 10'd1023: maximum cycles in RUN before abort.
- `clk` in 1: single clock, all state on posedge.
- `resetn` in 1: one clock; reset is synchronous and active-low.
- `req_valid` in 1 / `req_ready` out 1: request handshake; transfer when both are high at a posedge.
- `req_opcode` in 6, `req_vsew` in 3, `req_vs1` in 5, `req_vs2` in 5, `req_vd` in 5: operation, element width, register indices.
- `rf_raddr` out 5 / `rf_rdata` in VLEN: register file read port with 1-cycle latency.
- `rf_we` out 1, `rf_waddr` out 5, `rf_wdata` out VLEN: register file write port.
- `lane_run` out 1, `lane_opcode` out 6, `lane_vsew` out 3, `lane_vs1` out VLEN, `lane_vs2` out VLEN: broadcast to all lanes.
- `lane_done` in NL: per-lane done.
- `lane_vd` in NL*VLEN: lane i result at `[i*VLEN +: VLEN]`. A lane drives zeros outside the elements it owns.
- `resp_valid` out 1, `resp_err` out 1: completion pulse; `resp_err` is qualified by `resp_valid`.

## Operation
- States: IDLE, RD1, RD2, LOAD, RUN, WB, ERR.
- IDLE: `req_ready`=1. On handshake, latch opcode, vsew, and all indices.
  - Illegal request (opcode ≠ 6'b001001 vand, or vsew > 3) → ERR.
  - Otherwise → RD1.
- RD1: `rf_raddr`=vs1 index → RD2.
- RD2: `rf_raddr`=vs2 index; capture `rf_rdata` into the vs1 operand register → LOAD.
- LOAD: capture `rf_rdata` into the vs2 operand register; clear the timeout counter → RUN.
- RUN: `lane_run`=1, with `lane_vs1`, `lane_vs2`, `lane_opcode` and `lane_vsew` held stable.
  - When all bits of `lane_done` are 1: latch the OR of the NL `lane_vd` slices into `rf_wdata` → WB.
  - Else, when the counter reaches TIMEOUT → ERR. The counter increments every RUN cycle and saturates.
  - Lanes finishing early hold `done`. `lane_run` stays high until all lanes are done.
- WB: `rf_we`=1, `rf_waddr`=latched vd index, `resp_valid`=1, `resp_err`=0, `lane_run`=0 (lanes self-clear) → IDLE.
- ERR: `resp_valid`=1, `resp_err`=1, `rf_we`=0, `lane_run`=0 → IDLE.
- vd may equal vs1 or vs2. Operands are captured before writeback, so there is no hazard.
- No request queuing: `req_ready`=0 outside IDLE.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational input→output paths.
- Reset values:
  - State IDLE, but `req_ready`=0 during the reset cycle; it becomes 1 on the first cycle after `resetn` rises.
  - `rf_we`, `lane_run`, `resp_valid`, `resp_err` = 0.
  - `rf_raddr`, `rf_waddr`, `lane_opcode`, `lane_vsew` = 0.
  - `rf_wdata`, `lane_vs1`, `lane_vs2` = 0.
- Accept at edge T0:
  - RD1 in cycle T0+1, RD2 in T0+2, LOAD in T0+3.
  - `lane_run` high from T0+4.
  - If all lanes are done when sampled at edge T0+4+k, WB occurs in cycle T0+5+k.
  - IDLE (`req_ready`=1) one cycle after WB.
- Minimum issue-to-issue interval is 6+k cycles.
- Illegal request: ERR in cycle T0+1, `req_ready`=1 again in T0+2. The register file and lanes are untouched.
- Reset mid-operation (any state): next cycle is IDLE with reset values. No `rf_we`, no `resp_valid`. `lane_run` drops, so lanes reset.
- `lane_done` deasserting during RUN is ignored until all bits are simultaneously 1.
- Timeout and all-done in the same cycle: all-done wins (WB).

## Test plan
- vand, vsew=0, NL=2 real lanes, VLEN=128.
  - Stimulus: r1=all ones, r2=128'h0123456789ABCDEF_FEDCBA9876543210, vd=r3.
  - Required: `rf_we` pulse with waddr=3 and wdata=r2 value; `resp_valid`=1 with `resp_err`=0; `lane_run` first high exactly 4 cycles after accept.
- vand, vsew=2, vs1=vs2=vd=5 (r5=128'hA5A5...).
  - Required: r5 unchanged in value and written once; response `resp_err`=0.
- Illegal request: opcode 6'b000000, then vsew=3'b100.
  - Required: each yields `resp_valid`=1 with `resp_err`=1 one cycle after accept; no `rf_raddr` change, no `lane_run`, no `rf_we`.
- Staggered lanes: model lane0 done at 3 cycles and lane1 at 10 cycles.
  - Required: `lane_run` held for 10+ cycles; WB the cycle after lane1's done; merged wdata = lane0 OR lane1 slices.
- Timeout: lane_done stuck at 2'b01 with TIMEOUT=20.
  - Required: ERR response exactly 21 RUN cycles in; no `rf_we`; `req_ready`=1 next cycle.
- Reset mid-RUN: drop `resetn` for one cycle during RUN.
  - Required: no `rf_we` or `resp_valid`; all outputs at reset values; a fresh request afterward completes normally. Back-to-back requests with `req_valid` held high are accepted only in IDLE.
